// File: rtl/ita_activation_ctrl.sv
// Activation sequencer: issues tile beats to a fixed-latency activation datapath
// and collects the results in a credit-protected output FIFO.
module ita_activation_ctrl #(
  parameter int DW    = 128,
  parameter int LAT   = 5,
  parameter int DEPTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cfg_valid_i,
  output logic          cfg_ready_o,
  input  logic [1:0]    cfg_activation_i,
  input  logic [15:0]   cfg_len_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          act_calc_en_o,
  output logic          act_calc_en_q_o,
  output logic [1:0]    act_activation_o,
  output logic [DW-1:0] act_data_o,
  input  logic [DW-1:0] act_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o,
  output logic          busy_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [1:0]      act_q, act_d;
  logic [15:0]     len_q, len_d;
  logic [LAT-1:0]  vld_q, vld_d, lst_q, lst_d;
  logic [CW-1:0]   inflight_q, inflight_d, fcnt_q, fcnt_d;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [DW:0]     mem_q [DEPTH];
  logic            accept_s, last_beat_s, push_s, pop_s, empty_s;
  logic [CW:0]     credit_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_MAX) return {PW{1'b0}};
    else return p + PW'(1);
  endfunction

  assign empty_s     = (fcnt_q == {CW{1'b0}});
  assign credit_s    = {1'b0, inflight_q} + {1'b0, fcnt_q};
  assign in_ready_o  = (state_q == RUN) && (credit_s < DEPTH_C);
  assign accept_s    = in_valid_i && in_ready_o;
  assign last_beat_s = accept_s && (len_q == 16'd1);
  assign push_s      = vld_q[LAT-1];
  assign pop_s       = out_valid_o && out_ready_i;

  assign cfg_ready_o      = (state_q == IDLE);
  assign busy_o           = (state_q != IDLE);
  assign act_calc_en_o    = accept_s;
  assign act_calc_en_q_o  = vld_q[0];
  assign act_activation_o = act_q;
  assign act_data_o       = accept_s ? in_data_i : {DW{1'b0}};
  assign out_valid_o      = !empty_s;
  assign out_data_o       = empty_s ? {DW{1'b0}} : mem_q[rd_q][DW-1:0];
  assign out_last_o       = !empty_s && mem_q[rd_q][DW];

  // Tile sequencing: config latch, beat countdown, drain until the last beat leaves.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (cfg_valid_i && (cfg_len_i != 16'd0)) begin
          state_d = RUN;
          act_d   = cfg_activation_i;
          len_d   = cfg_len_i;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept_s) begin
          len_d = len_q - 16'd1;
          if (last_beat_s) state_d = DRAIN;
          else state_d = RUN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (pop_s && out_last_o) state_d = IDLE;
        else state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latency tag pipeline, in-flight credit and FIFO bookkeeping.
  always_comb begin
    vld_d    = {vld_q[LAT-1:0]};
    lst_d    = {lst_q[LAT-1:0]};
    vld_d[0] = accept_s;
    lst_d[0] = last_beat_s;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      lst_d[i] = lst_q[i-1];
    end
    case ({accept_s, push_s})
      2'b10:   inflight_d = inflight_q + ONE_C;
      2'b01:   inflight_d = inflight_q - ONE_C;
      default: inflight_d = inflight_q;
    endcase
    case ({push_s, pop_s})
      2'b10:   fcnt_d = fcnt_q + ONE_C;
      2'b01:   fcnt_d = fcnt_q - ONE_C;
      default: fcnt_d = fcnt_q;
    endcase
    if (push_s) wr_d = ptr_inc(wr_q);
    else wr_d = wr_q;
    if (pop_s) rd_d = ptr_inc(rd_q);
    else rd_d = rd_q;
  end

  // Control state; reset discards any partially processed tile.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      act_q      <= 2'd0;
      len_q      <= 16'd0;
      vld_q      <= {LAT{1'b0}};
      lst_q      <= {LAT{1'b0}};
      inflight_q <= {CW{1'b0}};
      fcnt_q     <= {CW{1'b0}};
      wr_q       <= {PW{1'b0}};
      rd_q       <= {PW{1'b0}};
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      len_q      <= len_d;
      vld_q      <= vld_d;
      lst_q      <= lst_d;
      inflight_q <= inflight_d;
      fcnt_q     <= fcnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  // Result storage; contents are qualified by the FIFO count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_s) mem_q[wr_q] <= {lst_q[LAT-1], act_data_i};
  end

  // Credit accounting must keep every result push within FIFO capacity.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_s && !pop_s && (fcnt_q == FULL_C)));

endmodule

// File: tb/tb_ita_activation_ctrl.sv
// Directed bench for ita_activation_ctrl with a fixed-latency XOR datapath stub.
module tb_ita_activation_ctrl;
  localparam int DW    = 128;
  localparam int LAT   = 5;
  localparam int DEPTH = 8;
  localparam logic [DW-1:0] XK = {16{8'h5A}};

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          cfg_valid_i, cfg_ready_o;
  logic [1:0]    cfg_activation_i;
  logic [15:0]   cfg_len_i;
  logic          in_valid_i, in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          act_calc_en_o, act_calc_en_q_o;
  logic [1:0]    act_activation_o;
  logic [DW-1:0] act_data_o, act_data_i;
  logic          out_valid_o, out_ready_i, out_last_o, busy_o;
  logic [DW-1:0] out_data_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0, send_n = 0, calc_n = 0, first_calc = -1, last_calc = -1, first_q = -1;
  int mon_bad = 0, tile_id = 0;
  logic [DW-1:0] out_d[$];
  logic          out_l[$];
  int            out_c[$];
  logic [DW-1:0] pipe [LAT];

  ita_activation_ctrl #(.DW(DW), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_activation_i(cfg_activation_i), .cfg_len_i(cfg_len_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .act_calc_en_o(act_calc_en_o), .act_calc_en_q_o(act_calc_en_q_o),
    .act_activation_o(act_activation_o), .act_data_o(act_data_o), .act_data_i(act_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Activation datapath stand-in: result = operand ^ XK, exactly LAT cycles later.
  always @(posedge clk_i) begin
    pipe[0] <= act_calc_en_o ? (act_data_o ^ XK) : {DW{1'b0}};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign act_data_i = pipe[LAT-1];

  // Mid-cycle monitor: issue rules and record every popped output beat.
  always @(negedge clk_i) begin
    if (in_valid_i && in_ready_o) acc_cnt = acc_cnt + 1;
    if (act_calc_en_o !== (in_valid_i && in_ready_o)) mon_bad++;
    if (act_calc_en_o) begin
      calc_n++;
      if (first_calc < 0) first_calc = cyc;
      last_calc = cyc;
      if (act_data_o !== in_data_i) mon_bad++;
    end else if (act_data_o !== {DW{1'b0}}) begin
      mon_bad++;
    end
    if (act_calc_en_q_o && first_q < 0) first_q = cyc;
    if (out_valid_o && out_ready_i) begin
      out_d.push_back(out_data_o);
      out_l.push_back(out_last_o);
      out_c.push_back(cyc);
    end
  end

  function automatic logic [DW-1:0] beat(input int t, input int k);
    return {8{t[7:0], k[7:0]}};
  endfunction

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    in_valid_i = (acc_cnt < send_n);
    in_data_i  = beat(tile_id, acc_cnt);
  endtask

  task automatic prep(input int tile, input int len);
    tile_id = tile; send_n = len; acc_cnt = 0; calc_n = 0;
    first_calc = -1; last_calc = -1; first_q = -1;
    out_d.delete(); out_l.delete(); out_c.delete();
    in_valid_i = (len > 0);
    in_data_i  = beat(tile, 0);
  endtask

  task automatic start_tile(input logic [1:0] act, input int len, input int tile);
    prep(tile, len);
    cfg_valid_i = 1'b1; cfg_activation_i = act; cfg_len_i = 16'(len);
    tick();
    cfg_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy_o && n < max) begin
      tick();
      n++;
    end
    check_eq({tag, "_idle"}, busy_o, 1'b0);
  endtask

  task automatic check_tile(input string tag, input int tile, input int len);
    int nb = 0;
    check_eq({tag, "_count"}, out_d.size(), len);
    for (int k = 0; k < out_d.size(); k++) begin
      if (out_d[k] !== (beat(tile, k) ^ XK)) nb++;
      if (out_l[k] !== (k == len - 1)) nb++;
    end
    check_eq({tag, "_data_last"}, nb, 0);
  endtask

  initial begin
    int idle_cyc, nbad, n;
    rst_ni = 1'b0; cfg_valid_i = 1'b0; cfg_activation_i = 2'd0; cfg_len_i = 16'd0;
    in_valid_i = 1'b0; in_data_i = {DW{1'b0}}; out_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_cfg_ready", cfg_ready_o, 1'b1);
    check_eq("rst_in_ready", in_ready_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_out_valid", out_valid_o, 1'b0);
    check_eq("rst_out_data", out_data_o, {DW{1'b0}});
    check_eq("rst_act", act_activation_o, 2'd0);
    check_eq("rst_calc_q", act_calc_en_q_o, 1'b0);
    rst_ni = 1'b1;
    tick();
    check_eq("post_rst_cfg_ready", cfg_ready_o, 1'b1);
    check_eq("post_rst_out_valid", out_valid_o, 1'b0);

    // Zero-length config: accepted, ignored.
    prep(9, 1);
    cfg_valid_i = 1'b1; cfg_activation_i = 2'd2; cfg_len_i = 16'd0;
    #1;
    check_eq("len0_cfg_ready", cfg_ready_o, 1'b1);
    tick();
    cfg_valid_i = 1'b0;
    check_eq("len0_busy", busy_o, 1'b0);
    repeat (3) tick();
    check_eq("len0_busy_later", busy_o, 1'b0);
    check_eq("len0_calc_n", calc_n, 0);
    send_n = 0;

    // Relu, len 4, streaming.
    out_ready_i = 1'b1;
    start_tile(2'd1, 4, 1);
    check_eq("t029_busy", busy_o, 1'b1);
    check_eq("t029_cfg_ready", cfg_ready_o, 1'b0);
    check_eq("t029_act", act_activation_o, 2'd1);
    wait_idle("t029", 40);
    idle_cyc = cyc;
    check_eq("t029_calc_n", calc_n, 4);
    check_eq("t029_calc_span", last_calc - first_calc, 3);
    check_eq("t029_calc_q", first_q - first_calc, 1);
    check_tile("t029", 1, 4);
    if (out_c.size() == 4) begin
      check_eq("t029_first_out", out_c[0] - first_q, LAT);
      check_eq("t029_last_out", out_c[3] - first_q, LAT + 3);
      check_eq("t029_busy_drop", idle_cyc - out_c[3], 1);
    end

    // Identity, len 20, output stalled: credit stops issue at DEPTH beats.
    out_ready_i = 1'b0;
    start_tile(2'd0, 20, 2);
    repeat (20) tick();
    check_eq("t030_accepted", acc_cnt, DEPTH);
    check_eq("t030_in_ready", in_ready_o, 1'b0);
    check_eq("t030_out_valid", out_valid_o, 1'b1);
    check_eq("t030_head", out_data_o, beat(2, 0) ^ XK);
    tick();
    check_eq("t030_head_held", out_data_o, beat(2, 0) ^ XK);
    check_eq("t030_head_last", out_last_o, 1'b0);
    out_ready_i = 1'b1;
    wait_idle("t030", 200);
    check_tile("t030", 2, 20);
    if (out_c.size() == 20) check_eq("t033_no_bubble", out_c[19] - out_c[0], 19);

    // New config held during RUN: ignored until the first IDLE cycle.
    start_tile(2'd1, 6, 3);
    cfg_valid_i = 1'b1; cfg_activation_i = 2'd2; cfg_len_i = 16'd2;
    nbad = 0; n = 0;
    while (busy_o && n < 60) begin
      if (act_activation_o !== 2'd1 || cfg_ready_o !== 1'b0) nbad++;
      tick();
      n++;
    end
    check_eq("t031_idle", busy_o, 1'b0);
    check_eq("t031_held", nbad, 0);
    check_eq("t031_cfg_ready", cfg_ready_o, 1'b1);
    check_tile("t031a", 3, 6);
    prep(4, 2);
    tick();
    cfg_valid_i = 1'b0;
    check_eq("t031_busy", busy_o, 1'b1);
    check_eq("t031_act", act_activation_o, 2'd2);
    wait_idle("t031b", 40);
    check_tile("t031b", 4, 2);

    // Reset asserted mid-DRAIN with 3 results waiting.
    out_ready_i = 1'b0;
    start_tile(2'd2, 3, 5);
    repeat (LAT + 4) tick();
    check_eq("t034_pre_valid", out_valid_o, 1'b1);
    check_eq("t034_pre_busy", busy_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    check_eq("t034_out_valid", out_valid_o, 1'b0);
    check_eq("t034_busy", busy_o, 1'b0);
    check_eq("t034_cfg_ready", cfg_ready_o, 1'b1);
    check_eq("t034_act", act_activation_o, 2'd0);
    check_eq("t034_out_data", out_data_o, {DW{1'b0}});
    check_eq("t034_in_ready", in_ready_o, 1'b0);
    tick();
    tick();
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    start_tile(2'd1, 2, 6);
    wait_idle("t034_post", 40);
    check_tile("t034_post", 6, 2);

    check_eq("issue_rules", mon_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
